// File: rtl/mnist_frame_loader.sv
// mnist_frame_loader: streams a grayscale frame in, binarises it into the
// model image, starts the model, waits for its result and returns the digit
// plus an error flag over a valid/ready result handshake.
module mnist_frame_loader #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned THRESH     = 128,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_last,
  output logic                  pix_ready,
  output logic [NUM_PIXELS-1:0] image_out,
  output logic                  model_start,
  input  logic [3:0]            model_digit,
  input  logic                  model_valid,
  output logic [3:0]            res_digit,
  output logic                  res_error,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int unsigned CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS + 1) : 1;
  localparam int unsigned TO_W  = 16;
  localparam int unsigned DIG_W = 4;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_PIXELS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [PIX_W-1:0] THRESH_V  = PIX_W'(THRESH);
  localparam logic [DIG_W-1:0] DIG_ABORT = DIG_W'(15);
  localparam logic [DIG_W-1:0] DIG_MAX   = DIG_W'(9);

  localparam logic [2:0] S_LOAD    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RESULT  = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [CNT_W-1:0] pix_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             valid_q;

  logic             pix_ready_n;
  logic             busy_n;
  logic             model_start_n;
  logic             res_valid_n;
  logic [DIG_W-1:0] res_digit_n;
  logic             res_error_n;

  logic             beat_c;
  logic             at_last_c;
  logic             done_c;
  logic             timeout_c;
  logic             pix_bit_c;
  logic [CNT_W-1:0] bit_idx_c;
  logic             res_take_c;

  // Handshake and datapath decode shared by the FSM and the datapath registers.
  assign beat_c     = pix_valid && pix_ready;
  assign at_last_c  = (pix_cnt == LAST_IDX);
  assign done_c     = model_valid && !valid_q;
  assign timeout_c  = (to_cnt == TO_LAST);
  assign pix_bit_c  = (pix_data >= THRESH_V);
  assign bit_idx_c  = LAST_IDX - pix_cnt;
  assign res_take_c = res_valid && res_ready;

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state;
    res_digit_n = res_digit;
    res_error_n = res_error;

    case (state)
      S_LOAD: begin
        if (beat_c) begin
          if (pix_last) begin
            if (at_last_c) begin
              state_n = S_START;
            end else begin
              // Short frame: report it without starting the model.
              state_n     = S_RESULT;
              res_digit_n = DIG_ABORT;
              res_error_n = 1'b1;
            end
          end else if (at_last_c) begin
            // Long frame: swallow the remainder up to pix_last.
            state_n = S_DISCARD;
          end
        end
      end

      S_DISCARD: begin
        if (beat_c && pix_last) begin
          state_n     = S_RESULT;
          res_digit_n = DIG_ABORT;
          res_error_n = 1'b1;
        end
      end

      S_START: begin
        state_n = S_WAIT;
      end

      S_WAIT: begin
        // A completion edge takes priority over a coincident timeout.
        if (done_c) begin
          state_n     = S_RESULT;
          res_digit_n = model_digit;
          res_error_n = (model_digit > DIG_MAX);
        end else if (timeout_c) begin
          state_n     = S_RESULT;
          res_digit_n = DIG_ABORT;
          res_error_n = 1'b1;
        end
      end

      S_RESULT: begin
        if (res_take_c) begin
          state_n = S_LOAD;
        end
      end

      default: begin
        state_n = S_LOAD;
      end
    endcase

    pix_ready_n   = (state_n == S_LOAD) || (state_n == S_DISCARD);
    busy_n        = (state_n != S_LOAD);
    model_start_n = (state_n == S_START);
    res_valid_n   = (state_n == S_RESULT);
  end

  // State register and registered control/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      pix_ready   <= 1'b1;
      busy        <= 1'b0;
      model_start <= 1'b0;
      res_valid   <= 1'b0;
      res_digit   <= '0;
      res_error   <= 1'b0;
    end else begin
      state       <= state_n;
      pix_ready   <= pix_ready_n;
      busy        <= busy_n;
      model_start <= model_start_n;
      res_valid   <= res_valid_n;
      res_digit   <= res_digit_n;
      res_error   <= res_error_n;
    end
  end

  // Image assembly: pixel k lands at bit NUM_PIXELS-1-k, only in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      image_out <= '0;
    end else if ((state == S_LOAD) && beat_c) begin
      image_out[bit_idx_c] <= pix_bit_c;
    end
  end

  // Pixel counter: advances per LOAD beat, rewinds when the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if ((state == S_RESULT) && res_take_c) begin
      pix_cnt <= '0;
    end else if ((state == S_LOAD) && beat_c) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

  // WAIT timeout counter: cleared in START so it reads zero on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == S_START) begin
      to_cnt <= '0;
    end else if (state == S_WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Model valid history, tracked in every state so a stale level is no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= model_valid;
    end
  end

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Testbench for mnist_frame_loader: frame stimulus, a model stub and a
// result scoreboard checked on every result handshake.
module tb_mnist_frame_loader;

  localparam int NP = 784;

  typedef struct packed {
    logic [3:0] digit;
    logic       err;
  } res_t;

  logic          clk;
  logic          rst;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_last;
  logic          pix_ready;
  logic [NP-1:0] image_out;
  logic          model_start;
  logic [3:0]    model_digit;
  logic          model_valid;
  logic [3:0]    res_digit;
  logic          res_error;
  logic          res_valid;
  logic          res_ready;
  logic          busy;

  int            n_checks = 0;
  int            n_errors = 0;
  int            start_cycles = 0;
  int            stub_mode = 0;
  logic [3:0]    stub_digit = 4'd0;
  int            stub_delay = 2;
  logic [7:0]    pix_mem [0:1023];
  logic [NP-1:0] exp_img;
  res_t          sb_q [$];

  mnist_frame_loader #(
    .NUM_PIXELS(NP),
    .PIX_W     (8),
    .THRESH    (128),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .image_out  (image_out),
    .model_start(model_start),
    .model_digit(model_digit),
    .model_valid(model_valid),
    .res_digit  (res_digit),
    .res_error  (res_error),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive point: just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ones(input logic [NP-1:0] v);
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int img_diff();
    return ones(image_out ^ exp_img);
  endfunction

  function automatic bit seven_bit(input int k);
    int row = k / 28;
    int col = k % 28;
    int c0;
    if (row >= 4 && row <= 6 && col >= 6 && col <= 21) return 1'b1;
    if (row >= 7 && row <= 23) begin
      c0 = 21 - (row - 7) / 2;
      if (col >= c0 - 2 && col <= c0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic build_exp(input int n);
    exp_img = '0;
    for (int k = 0; k < n && k < NP; k++) exp_img[NP-1-k] = (pix_mem[k] >= 8'd128);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 1024; k++) pix_mem[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, output int stall);
    stall = 0;
    pix_data  = d;
    pix_valid = 1'b1;
    pix_last  = last;
    while (!pix_ready && stall < 50) begin
      tick();
      stall++;
    end
    if (!pix_ready) check_eq("beat_accept", pix_ready, 1);
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_idx, output int stalls);
    int st;
    stalls = 0;
    for (int k = 0; k < nbeats; k++) begin
      send_beat(pix_mem[k], (k == last_idx), st);
      stalls += st;
    end
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!res_valid) check_eq("res_timeout", res_valid, 1);
  endtask

  // One frame: push the expected result, stream it, and check image/latency/starts.
  task automatic run_frame(input string name, input int nbeats, input int last_idx,
                           input logic [3:0] exp_digit, input logic exp_err,
                           input int exp_starts, input int exp_lat, input bit img_ok);
    int   s0, lat, stalls;
    res_t e;
    e.digit = exp_digit;
    e.err   = exp_err;
    sb_q.push_back(e);
    build_exp(nbeats);
    s0 = start_cycles;
    send_frame(nbeats, last_idx, stalls);
    check_eq({name, "_stalls"}, stalls, 0);
    if (img_ok) begin
      check_eq({name, "_img"}, img_diff(), 0);
      check_eq({name, "_start_now"}, model_start, 1);
      check_eq({name, "_busy"}, busy, 1);
      check_eq({name, "_rdy_low"}, pix_ready, 0);
    end
    wait_result(lat);
    check_eq({name, "_lat"}, lat, exp_lat);
    if (img_ok) check_eq({name, "_img_hold"}, img_diff(), 0);
    check_eq({name, "_starts"}, start_cycles - s0, exp_starts);
  endtask

  task automatic release_result(input string name);
    tick();
    check_eq({name, "_rel_ready"}, pix_ready, 1);
    check_eq({name, "_rel_valid"}, res_valid, 0);
  endtask

  // Count model_start high cycles.
  always @(negedge clk) begin
    if (model_start) start_cycles++;
  end

  // Model stub: edge response after a delay, or a stale constant-high level.
  initial begin
    model_valid = 1'b0;
    model_digit = 4'd0;
    forever begin
      @(negedge clk);
      if (stub_mode == 1) begin
        model_digit = stub_digit;
        model_valid = 1'b1;
      end else if (model_start) begin
        repeat (stub_delay) @(negedge clk);
        model_digit = stub_digit;
        model_valid = 1'b1;
        repeat (3) @(negedge clk);
        model_valid = 1'b0;
      end else begin
        model_valid = 1'b0;
      end
    end
  end

  // Scoreboard: compare each accepted result with the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (!rst && res_valid && res_ready) begin
      check_eq("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("res_digit", res_digit, e.digit);
        check_eq("res_error", res_error, e.err);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int st;
    rst       = 1'b1;
    pix_data  = 8'd0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    res_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check_eq("rst_img_ones", ones(image_out), 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_start", model_start, 0);
    check_eq("rst_pix_ready", pix_ready, 1);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // "7" test image, model returns 7
    for (int k = 0; k < NP; k++) pix_mem[k] = seven_bit(k) ? 8'd255 : 8'd0;
    stub_digit = 4'd7;
    run_frame("seven", NP, NP - 1, 4'd7, 1'b0, 1, 3, 1'b1);
    release_result("seven");

    // Threshold boundary at pixels 0 and 1
    fill_random();
    pix_mem[0] = 8'd127;
    pix_mem[1] = 8'd128;
    stub_digit = 4'd1;
    run_frame("thresh", NP, NP - 1, 4'd1, 1'b0, 1, 3, 1'b1);
    release_result("thresh");
    check_eq("thr_127", image_out[NP-1], 0);
    check_eq("thr_128", image_out[NP-2], 1);

    // Short frame: no model start, abort result
    run_frame("short", 100, 99, 4'hF, 1'b1, 0, 0, 1'b0);
    release_result("short");

    // Long frame: ready held through all 800 beats, abort result
    run_frame("long", 800, 799, 4'hF, 1'b1, 0, 0, 1'b0);
    release_result("long");

    // Stale model_valid level: only the timeout can end WAIT
    fill_random();
    stub_digit = 4'd5;
    stub_mode  = 1;
    run_frame("stale", NP, NP - 1, 4'hF, 1'b1, 1, 17, 1'b1);
    release_result("stale");
    stub_mode = 0;

    // Out-of-range digit from the model
    fill_random();
    stub_digit = 4'd12;
    run_frame("dig12", NP, NP - 1, 4'd12, 1'b1, 1, 3, 1'b1);
    release_result("dig12");

    // Result backpressure
    fill_random();
    stub_digit = 4'd3;
    res_ready  = 1'b0;
    run_frame("bp", NP, NP - 1, 4'd3, 1'b0, 1, 3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", res_valid, 1);
      check_eq("bp_digit", res_digit, 3);
      check_eq("bp_ready", pix_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    release_result("bp");

    // Reset in the middle of a frame, then a clean frame from pixel 0
    fill_random();
    send_frame(400, -1, st);
    rst = 1'b1;
    tick();
    tick();
    check_eq("mrst_img_ones", ones(image_out), 0);
    check_eq("mrst_ready", pix_ready, 1);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_valid", res_valid, 0);
    rst = 1'b0;
    tick();
    fill_random();
    stub_digit = 4'd9;
    run_frame("after_rst", NP, NP - 1, 4'd9, 1'b0, 1, 3, 1'b1);
    release_result("after_rst");

    check_eq("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
